// File: rtl/hankel_sample_buf_if.sv
// Bundle of the load/stream/read/status signals between hankel_sample_buf and
// its neighbours. The master side is whoever drives the buffer (upstream stream
// plus hankel_matrix); the slave side is the buffer itself.
interface hankel_sample_buf_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          load;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          start;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          done;
  logic [AW:0]   fill_cnt;
  logic          busy;
  logic          ovf;
  logic          rd_err;

  modport master (
    output load, in_valid, in_data, rd, addr, done,
    input  in_ready, start, data, fill_cnt, busy, ovf, rd_err
  );

  modport slave (
    input  load, in_valid, in_data, rd, addr, done,
    output in_ready, start, data, fill_cnt, busy, ovf, rd_err
  );
endinterface

// File: rtl/hankel_sample_buf.sv
// Sample buffer feeding hankel_matrix: captures FILL_LEN samples from a
// valid/ready stream, pulses start once the block is complete, then serves
// zero-latency reads until the consumer reports done.
module hankel_sample_buf #(
  parameter int DW       = 16,
  parameter int AW       = 8,
  parameter int FILL_LEN = 64
) (
  input logic              clk,
  input logic              rst,
  hankel_sample_buf_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, ARM, SERVE} state_t;

  // Block length as a count, and the write address that completes the block.
  localparam logic [AW:0]   LEN  = (AW+1)'(FILL_LEN);
  localparam logic [AW-1:0] LAST = AW'(FILL_LEN - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill_cnt;
  logic          ovf_q, rd_err_q;
  logic          load_acc, wr_en, rd_hit, ovf_ev, rd_err_ev;

  // State register; reset aborts any block in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the state-derived handshake and status outputs.
  always_comb begin
    state_nxt    = state;
    load_acc     = 1'b0;
    wr_en        = 1'b0;
    bus.in_ready = 1'b0;
    bus.start    = 1'b0;
    bus.busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.load) begin
          load_acc  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST) state_nxt = ARM;
        end
      end
      ARM: begin
        bus.start = 1'b1;
        state_nxt = SERVE;
      end
      SERVE: begin
        if (bus.done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A read hits only while serving and inside the captured block; anything
  // else returns all-ones and is flagged. A sample offered while not ready is dropped.
  assign rd_hit    = (state == SERVE) && bus.rd && ({1'b0, bus.addr} < LEN);
  assign rd_err_ev = bus.rd && !rd_hit;
  assign ovf_ev    = bus.in_valid && (state != FILL);
  assign bus.data  = rd_hit ? mem[bus.addr] : {DW{1'b1}};

  // Write pointer, fill count and sticky error flags; an accepted load clears
  // the flags but an error seen in that same cycle still sets them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      ovf_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (load_acc) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
      end else if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fill_cnt <= fill_cnt + 1'b1;
      end
      ovf_q    <= (ovf_q & ~load_acc) | ovf_ev;
      rd_err_q <= (rd_err_q & ~load_acc) | rd_err_ev;
    end
  end

  // Sample RAM; contents survive reset, only accepted stream beats write it.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.fill_cnt = fill_cnt;
  assign bus.ovf      = ovf_q;
  assign bus.rd_err   = rd_err_q;

endmodule
